state_dump_unit: RTL
====================

Name: state_dump_unit

Overview:
- Read-side counterpart to the bench's memory image loading: where the bench preloads the register file and data memory, this block reads them back out of the stopped pipeline.
- After software or a bench asserts start, it walks every register-file entry, then every data-memory word, through their asynchronous read ports.
- Each word is streamed out on a valid/ready interface, followed by one checksum beat.
- Sits beside mips_pipeline and lets a host or the bench capture final architectural state without hierarchical peeking.

Parameters:
- RF_DEPTH, 32, number of register-file entries dumped (power of two).
- DM_DEPTH, 32, number of data-memory words dumped; matches DATA_MEM_LENGTH (power of two).
- DW, 32, word width.
- RF_AW, 5, register-file address width, log2(RF_DEPTH).
- DM_AW, 5, data-memory word-address width, log2(DM_DEPTH).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a dump; honoured only in IDLE.
- busy  out  1  high from the cycle after an accepted start until the checksum beat is accepted.
- done  out  1  one-cycle pulse in the cycle after the checksum beat handshakes.
- rf_raddr  out  RF_AW  register-file read address.
- rf_rdata  in  DW  combinational read data for rf_raddr.
- dm_raddr  out  DM_AW  data-memory word read address.
- dm_rdata  in  DW  combinational read data for dm_raddr.
- out_valid  out  1  out_data, out_sel and out_index are valid.
- out_ready  in  1  consumer accepts the beat.
- out_data  out  DW  dumped word or checksum.
- out_sel  out  2  beat source: 0 = RF, 1 = DM, 2 = checksum.
- out_index  out  max(RF_AW,DM_AW)  entry index; 0 for the checksum beat.

Behaviour:
- States: IDLE, RF, DM, SUM, FIN.
- Reset values: state IDLE; all outputs 0; address counters 0; checksum accumulator 0.
- Output slot is a single register. It loads when out_valid==0 or (out_valid && out_ready).
- IDLE: start=1 → next state RF, counter = 0, accumulator = 0, busy = 1. start while busy is ignored.
- RF state:
  - rf_raddr = counter.
  - When the slot can load: out_data <= rf_rdata, out_sel <= 0, out_index <= counter, out_valid <= 1, accumulator += rf_rdata (mod 2^DW), counter++.
  - After loading entry RF_DEPTH-1: counter = 0, next state DM.
  - If the slot cannot load (stalled), counter, address and accumulator hold.
- DM state: same as RF using dm_raddr/dm_rdata with out_sel = 1. After entry DM_DEPTH-1, next state SUM.
- SUM state: when the slot can load, out_data <= accumulator (which includes every RF and DM word), out_sel <= 2, out_index <= 0; next state FIN.
- FIN state:
  - When the checksum beat handshakes: out_valid <= 0, busy <= 0, done <= 1 for one cycle, next state IDLE.
  - If the checksum handshakes in the same cycle that start is high, start is ignored; start is only honoured in IDLE.
- Timing: first beat is valid 2 cycles after the start cycle (start at edge N → RF at N+1 → out_valid at N+2).
- Throughput: 1 beat/cycle with out_ready held high. Total beats = RF_DEPTH + DM_DEPTH + 1.
- Handshake rules:
  - While out_valid && !out_ready, out_data, out_sel and out_index are stable.
  - out_valid never drops without a handshake, except on rst.
- rf_raddr and dm_raddr are 0 outside their own states.
- Counters never exceed depth-1; no wrap-around into the next region.
- rst mid-dump aborts immediately to the reset values; no done pulse; no partial checksum beat.
- The block never writes either memory.

Test Plan:
- RF[i]=i, DM[j]=0x100+j, out_ready=1, start pulse → 65 beats:
  - RF 0..31, then DM 0x100..0x11F.
  - Checksum beat = 496 + 32×256 + 496 = 0x23E0.
  - First beat 2 cycles after start; done pulses once; busy low afterwards.
- Same image, out_ready toggling 1-0-1-0, plus a 5-cycle stall at beat 31 (RF[31]) → identical beat sequence and checksum; outputs stable during every stall.
- All words 0xFFFFFFFF → checksum = 64×0xFFFFFFFF mod 2^32 = 0xFFFFFFC0, confirming wraparound addition.
- start asserted again at beats 10 and 40 → ignored; exactly 65 beats.
- rst asserted at beat 20 → next cycle out_valid=0, busy=0, no done. A new start then produces a full 65-beat dump from RF[0].
- Back-to-back dumps: start in the cycle after done → second dump identical to the first.

Source files
------------

// File: rtl/state_dump_unit.sv
// state_dump_unit: after a start request, reads every register-file entry and
// then every data-memory word through their asynchronous read ports, streams
// each word out on a valid/ready interface, and finishes with one beat holding
// the modulo-2^DW sum of all words dumped.
module state_dump_unit #(
  parameter int RF_DEPTH = 32,
  parameter int DM_DEPTH = 32,
  parameter int DW       = 32,
  parameter int RF_AW    = 5,
  parameter int DM_AW    = 5,
  localparam int IW      = (RF_AW > DM_AW) ? RF_AW : DM_AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic [RF_AW-1:0] rf_raddr,
  input  logic [DW-1:0] rf_rdata,
  output logic [DM_AW-1:0] dm_raddr,
  input  logic [DW-1:0] dm_rdata,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [1:0]    out_sel,
  output logic [IW-1:0] out_index
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RF,
    S_DM,
    S_SUM,
    S_FIN
  } state_e;

  localparam logic [1:0]    SEL_RF  = 2'd0;
  localparam logic [1:0]    SEL_DM  = 2'd1;
  localparam logic [1:0]    SEL_SUM = 2'd2;
  localparam logic [IW-1:0] RF_LAST = IW'(RF_DEPTH - 1);
  localparam logic [IW-1:0] DM_LAST = IW'(DM_DEPTH - 1);

  state_e        state_q, state_d;
  logic [IW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] acc_q, acc_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          out_valid_q, out_valid_d;
  logic [DW-1:0] out_data_q, out_data_d;
  logic [1:0]    out_sel_q, out_sel_d;
  logic [IW-1:0] out_index_q, out_index_d;
  logic          can_load;

  // The output slot may take a new word when it is empty or being drained now.
  assign can_load = !out_valid_q || out_ready;

  // Read addresses follow the walk counter only in their own region, else 0.
  assign rf_raddr = (state_q == S_RF) ? cnt_q[RF_AW-1:0] : '0;
  assign dm_raddr = (state_q == S_DM) ? cnt_q[DM_AW-1:0] : '0;

  assign busy      = busy_q;
  assign done      = done_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;
  assign out_index = out_index_q;

  // Next-state logic: walk RF, then DM, then emit the checksum and wait for it to drain.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    out_index_d = out_index_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RF;
          cnt_d   = '0;
          acc_d   = '0;
          busy_d  = 1'b1;
        end
      end
      S_RF: begin
        if (can_load) begin
          out_data_d  = rf_rdata;
          out_sel_d   = SEL_RF;
          out_index_d = cnt_q;
          out_valid_d = 1'b1;
          acc_d       = acc_q + rf_rdata;
          if (cnt_q == RF_LAST) begin
            cnt_d   = '0;
            state_d = S_DM;
          end else begin
            cnt_d = cnt_q + IW'(1);
          end
        end
      end
      S_DM: begin
        if (can_load) begin
          out_data_d  = dm_rdata;
          out_sel_d   = SEL_DM;
          out_index_d = cnt_q;
          out_valid_d = 1'b1;
          acc_d       = acc_q + dm_rdata;
          if (cnt_q == DM_LAST) begin
            cnt_d   = '0;
            state_d = S_SUM;
          end else begin
            cnt_d = cnt_q + IW'(1);
          end
        end
      end
      S_SUM: begin
        if (can_load) begin
          out_data_d  = acc_q;
          out_sel_d   = SEL_SUM;
          out_index_d = '0;
          out_valid_d = 1'b1;
          state_d     = S_FIN;
        end
      end
      S_FIN: begin
        // Start is deliberately not looked at here; it only counts in IDLE.
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          busy_d      = 1'b0;
          done_d      = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers with synchronous reset that aborts any dump.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      out_index_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      out_index_q <= out_index_d;
    end
  end

endmodule
